// File: rtl/disp_scan_driver.sv
// disp_scan_driver: converts an 8-bit count to BCD with a sequential
// double-dabble and scans three digits onto one code bus with
// active-low anodes; an optional "HA" message mode is also provided.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   value      binary count, captured on value_load
//   value_load strobe, starts a conversion when not busy
//   show_ha    level, displays "HA" instead of the number
//   busy       high while a conversion is running (9 cycles)
//   code       registered digit code (0-9, A = H, B = A)
//   an         registered active-low anodes {hun, ten, one}
module disp_scan_driver #(
   parameter int SCAN_DIV = 50000,
   parameter int LZ_BLANK = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] value,
   input  logic       value_load,
   input  logic       show_ha,
   output logic       busy,
   output logic [3:0] code,
   output logic [2:0] an
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t        state;
   logic [7:0]    bin;
   logic [9:0]    bcd;
   logic [9:0]    adj;
   logic [3:0]    iter;
   logic [1:0]    hun;
   logic [3:0]    ten;
   logic [3:0]    one;
   logic [PW-1:0] pre;
   logic [1:0]    idx;

   // Hundreds never exceeds 2 for an 8-bit input, so only the two
   // lower nibbles need the add-3 correction.
   always_comb begin
      adj = bcd;
      if (bcd[3:0] >= 4'd5) adj[3:0] = bcd[3:0] + 4'd3;
      if (bcd[7:4] >= 4'd5) adj[7:4] = bcd[7:4] + 4'd3;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         bin   <= '0;
         bcd   <= '0;
         iter  <= '0;
         hun   <= '0;
         ten   <= '0;
         one   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (value_load) begin
                  bin   <= value;
                  bcd   <= '0;
                  iter  <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               bcd  <= {adj[8:0], bin[7]};
               bin  <= {bin[6:0], 1'b0};
               iter <= iter + 4'd1;
               if (iter == 4'd7) state <= DONE;
            end
            DONE: begin
               // Digits update together so the display never tears.
               hun   <= bcd[9:8];
               ten   <= bcd[7:4];
               one   <= bcd[3:0];
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
         idx <= '0;
      end else if (pre == PMAX) begin
         pre <= '0;
         idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         code <= 4'h0;
         an   <= 3'b111;
      end else begin
         unique case (idx)
            2'd0: begin
               code <= show_ha ? 4'hB : one;
               an   <= 3'b110;
            end
            2'd1: begin
               code <= show_ha ? 4'hA : ten;
               if (!show_ha && LZ_BLANK != 0 &&
                   hun == 2'd0 && ten == 4'd0)
                  an <= 3'b111;
               else
                  an <= 3'b101;
            end
            default: begin
               code <= show_ha ? 4'h0 : {2'b00, hun};
               if (show_ha ||
                   (LZ_BLANK != 0 && hun == 2'd0))
                  an <= 3'b111;
               else
                  an <= 3'b011;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_disp_scan_driver.sv
// tb_disp_scan_driver: scoreboard bench with a decimal-arithmetic
// reference model, driving two instances with different parameters.
module tb_disp_scan_driver;

   logic       clk;
   logic       rst;
   logic [7:0] value;
   logic       value_load;
   logic       show_ha;
   logic       busy0;
   logic       busy1;
   logic [3:0] code0;
   logic [3:0] code1;
   logic [2:0] an0;
   logic [2:0] an1;

   int total;
   int bad;

   typedef struct {
      logic       busy;
      logic [6:0] o0;
      logic [6:0] o1;
   } exp_t;

   exp_t sbq[$];

   int m_cnt;
   int m_pend;
   int m_disp;
   int m_cyc;

   disp_scan_driver #(
      .SCAN_DIV(4),
      .LZ_BLANK(1)
   ) dut0 (
      .clk(clk),
      .rst(rst),
      .value(value),
      .value_load(value_load),
      .show_ha(show_ha),
      .busy(busy0),
      .code(code0),
      .an(an0)
   );

   disp_scan_driver #(
      .SCAN_DIV(1),
      .LZ_BLANK(0)
   ) dut1 (
      .clk(clk),
      .rst(rst),
      .value(value),
      .value_load(value_load),
      .show_ha(show_ha),
      .busy(busy1),
      .code(code1),
      .an(an1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {code, an} for the digit selected after cyc edges.
   function automatic logic [6:0] exp_out(
      input int cyc,
      input int div,
      input bit lz,
      input int disp,
      input bit ha
   );
      int d;
      int h;
      int t;
      int o;
      logic [3:0] c;
      logic [2:0] a;
      d = (cyc / div) % 3;
      h = disp / 100;
      t = (disp / 10) % 10;
      o = disp % 10;
      if (ha) begin
         c = (d == 0) ? 4'hB : (d == 1) ? 4'hA : 4'h0;
         a = (d == 0) ? 3'b110 : (d == 1) ? 3'b101 : 3'b111;
      end else if (d == 0) begin
         c = 4'(o);
         a = 3'b110;
      end else if (d == 1) begin
         c = 4'(t);
         a = (lz && h == 0 && t == 0) ? 3'b111 : 3'b101;
      end else begin
         c = 4'(h);
         a = (lz && h == 0) ? 3'b111 : 3'b011;
      end
      return {c, a};
   endfunction

   task automatic step(
      input bit         r,
      input bit         ld,
      input logic [7:0] v,
      input bit         ha
   );
      exp_t e;
      @(negedge clk);
      rst        = r;
      value_load = ld;
      value      = v;
      show_ha    = ha;
      if (r) begin
         m_cnt  = 0;
         m_disp = 0;
         m_cyc  = 0;
         e.busy = 1'b0;
         e.o0   = 7'h07;
         e.o1   = 7'h07;
      end else begin
         e.o0 = exp_out(m_cyc, 4, 1'b1, m_disp, ha);
         e.o1 = exp_out(m_cyc, 1, 1'b0, m_disp, ha);
         m_cyc++;
         if (m_cnt == 0) begin
            if (ld) begin
               m_cnt  = 9;
               m_pend = int'(v);
            end
         end else begin
            m_cnt--;
            if (m_cnt == 0) m_disp = m_pend;
         end
         e.busy = (m_cnt != 0);
      end
      sbq.push_back(e);
   endtask

   task automatic idle(input int n, input bit ha);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, ha);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            total++;
            if (busy0 !== e.busy || busy1 !== e.busy) begin
               bad++;
               $display("FAIL busy: got %b/%b want %b",
                        busy0, busy1, e.busy);
            end
            total++;
            if ({code0, an0} !== e.o0) begin
               bad++;
               $display("FAIL dut0 code/an: got %h/%b want %h/%b",
                        code0, an0, e.o0[6:3], e.o0[2:0]);
            end
            total++;
            if ({code1, an1} !== e.o1) begin
               bad++;
               $display("FAIL dut1 code/an: got %h/%b want %h/%b",
                        code1, an1, e.o1[6:3], e.o1[2:0]);
            end
         end
      end
   end

   initial begin : driver
      bit r;
      bit ld;
      bit ha;
      total      = 0;
      bad        = 0;
      m_cnt      = 0;
      m_pend     = 0;
      m_disp     = 0;
      m_cyc      = 0;
      rst        = 1'b1;
      value      = 8'h00;
      value_load = 1'b0;
      show_ha    = 1'b0;

      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      idle(13, 1'b0);

      step(1'b0, 1'b1, 8'd255, 1'b0);
      idle(30, 1'b0);

      step(1'b0, 1'b1, 8'd7, 1'b0);
      idle(20, 1'b0);

      step(1'b0, 1'b1, 8'd100, 1'b0);
      idle(2, 1'b0);
      step(1'b0, 1'b1, 8'd42, 1'b0);
      idle(5, 1'b0);
      step(1'b0, 1'b1, 8'd42, 1'b0);
      idle(20, 1'b0);

      idle(15, 1'b1);
      idle(15, 1'b0);

      step(1'b0, 1'b1, 8'd200, 1'b0);
      idle(4, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      idle(3, 1'b0);
      step(1'b0, 1'b1, 8'd200, 1'b0);
      idle(25, 1'b0);

      step(1'b0, 1'b1, 8'd0, 1'b0);
      idle(20, 1'b0);

      ha = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 299) == 0);
         ld = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) ha = ~ha;
         step(r, ld, 8'($urandom_range(0, 255)), ha);
      end
      idle(5, 1'b0);

      @(posedge clk);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
